// File: rtl/fairy_data_sram_slave.sv
// -----------------------------------------------------------------------------
// fairy_data_sram_slave
//
// Data-memory responder for the data_sram_* interface of the memory pipeline
// stage. Holds the whole data RAM array, accepts one request per cycle and
// returns read data one cycle later. Stores are posted into a one-entry write
// buffer that commits on the following edge; reads merge the buffered bytes
// over the array word so a load right after a store sees the new bytes.
//
// Handshake: there is no valid/ready pair. Every cycle is a request (read when
// data_sram_wr_i is 0, write when it is 1); the slave is always ready and never
// applies back-pressure.
//
// Parameters:
//   ADDR_W    word-address width, array depth = 2**ADDR_W 32-bit words
//   INIT_VAL  power-up value of every array word (reset does not re-apply it)
//
// Ports:
//   clk                 system clock, all state on rising edge
//   reset               synchronous reset, active-high
//   data_sram_addr_i    byte address; word index = addr[ADDR_W+1:2]
//   data_sram_cen_i     byte-lane enables for writes
//   data_sram_wdata_i   write data, lanes pre-replicated by the initiator
//   data_sram_wr_i      1 = write cycle, 0 = read cycle (X reads)
//   data_sram_rdata_o   read data for the address of the previous cycle
//   wbuf_busy_o         posted write pending commit
//   range_err_o         sticky out-of-range flag (FAIRY_DSRAM_RANGE_CHECK_EN only)
//
// Optional feature macro: FAIRY_DSRAM_RANGE_CHECK_EN
//   Defined: addresses with bits above ADDR_W+1 set are flagged on range_err_o,
//   out-of-range writes are dropped and out-of-range reads return 32'hDEAD_BEEF.
//   Undefined: no check, addresses alias modulo 2**(ADDR_W+2).
// -----------------------------------------------------------------------------
module fairy_data_sram_slave #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_sram_addr_i,
  input  logic [3:0]  data_sram_cen_i,
  input  logic [31:0] data_sram_wdata_i,
  input  logic        data_sram_wr_i,
  output logic [31:0] data_sram_rdata_o,
  output logic        wbuf_busy_o
`ifdef FAIRY_DSRAM_RANGE_CHECK_EN
  ,
  output logic        range_err_o
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

  // Array contents are set once at power-up; reset deliberately leaves them.
  logic [31:0] mem_q [DEPTH] = '{default: INIT_VAL};

  // Posted write buffer.
  logic              wbuf_valid_q;
  logic [ADDR_W-1:0] wbuf_idx_q;
  logic [31:0]       wbuf_data_q;
  logic [3:0]        wbuf_cen_q;

  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] req_idx;
  logic              req_oor;
  logic [31:0]       merged_word;

  assign req_idx = data_sram_addr_i[ADDR_W+1:2];

  // Byte offset bits never affect word selection.
  logic unused_addr_lo;
  assign unused_addr_lo = ^data_sram_addr_i[1:0];

`ifdef FAIRY_DSRAM_RANGE_CHECK_EN
  logic range_err_q;

  assign req_oor     = |data_sram_addr_i[31:ADDR_W+2];
  assign range_err_o = range_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      range_err_q <= 1'b0;
    end else if (req_oor) begin
      range_err_q <= 1'b1;
    end
  end
`else
  // Upper bits are ignored: the address aliases onto the array.
  logic unused_addr_hi;
  assign unused_addr_hi = ^data_sram_addr_i[31:ADDR_W+2];
  assign req_oor        = 1'b0;
`endif

  // Merge buffered lanes over the array word. Because the buffer commits on
  // the same edge that captures this read, the merge equals post-commit data.
  always_comb begin
    merged_word = mem_q[req_idx];
    for (int k = 0; k < 4; k++) begin
      if (wbuf_valid_q && (wbuf_idx_q == req_idx) && wbuf_cen_q[k]) begin
        merged_word[8*k +: 8] = wbuf_data_q[8*k +: 8];
      end
    end
  end

  // Request handling: capture writes into the buffer, register read data.
  // An X on data_sram_wr_i falls to the read branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q      <= 32'h0000_0000;
      wbuf_valid_q <= 1'b0;
      wbuf_idx_q   <= '0;
      wbuf_data_q  <= 32'h0000_0000;
      wbuf_cen_q   <= 4'b0000;
    end else if (data_sram_wr_i) begin
      // A write with no lanes, or one out of range, leaves the buffer empty;
      // rdata holds its previous value across write cycles.
      wbuf_valid_q <= (data_sram_cen_i != 4'b0000) && !req_oor;
      wbuf_idx_q   <= req_idx;
      wbuf_data_q  <= data_sram_wdata_i;
      wbuf_cen_q   <= data_sram_cen_i;
    end else begin
      wbuf_valid_q <= 1'b0;
      rdata_q      <= req_oor ? OOR_RDATA : merged_word;
    end
  end

  // Commit: a valid entry drains into the array on the edge after capture,
  // regardless of the current request. Reset discards it instead.
  always_ff @(posedge clk) begin
    if (!reset && wbuf_valid_q) begin
      for (int k = 0; k < 4; k++) begin
        if (wbuf_cen_q[k]) begin
          mem_q[wbuf_idx_q][8*k +: 8] <= wbuf_data_q[8*k +: 8];
        end
      end
    end
  end

  assign data_sram_rdata_o = rdata_q;
  assign wbuf_busy_o       = wbuf_valid_q;

endmodule
